writeback_retire_unit: RTL

- Parametrised successor to the single-issue writeback stage: retires up to NUM_CH MEM/WB results per cycle.
- Performs load alignment and extension, resolves same-cycle register-file write conflicts and suppresses writes to r0.
- Replaces the combinational $finish on SYSCALL with a registered halt sequence and a retired-instruction counter.
- Sits between the MEM/WB pipeline register and the register-file write ports.

---
 rtl/writeback_retire_unit.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/writeback_retire_unit.sv
// Writeback/retire stage: aligns and extends load data, resolves same-cycle register-file
// write conflicts, drops r0 writes, counts retired instructions and runs the SYSCALL halt sequence.
module writeback_retire_unit #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned DRAIN_CYC = 2,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          in_valid,
    input  logic [NUM_CH-1:0]          in_reg_write,
    input  logic [NUM_CH*REG_AW-1:0]   in_reg_dst,
    input  logic [NUM_CH*DATA_W-1:0]   in_result,
    input  logic [NUM_CH-1:0]          in_is_load,
    input  logic [NUM_CH*2-1:0]        in_load_size,
    input  logic [NUM_CH-1:0]          in_load_unsigned,
    input  logic [NUM_CH*3-1:0]        in_byte_off,
    input  logic [NUM_CH-1:0]          in_is_syscall,
    output logic [NUM_CH-1:0]          wb_en,
    output logic [NUM_CH*REG_AW-1:0]   wb_dst,
    output logic [NUM_CH*DATA_W-1:0]   wb_data,
    output logic [CNT_W-1:0]           retired_count,
    output logic                       halt_pending,
    output logic                       halted
);

    localparam int unsigned OFF_MASK = DATA_W / 8 - 1;
    localparam int unsigned DCW      = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALT
    } state_t;

    state_t                     state_q, state_d;
    logic [DCW-1:0]             drain_q, drain_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [NUM_CH-1:0]          wb_en_q, wb_en_d;
    logic [NUM_CH*REG_AW-1:0]   wb_dst_q;
    logic [NUM_CH*DATA_W-1:0]   wb_data_q, wb_data_d;
    logic [NUM_CH-1:0]          killed, retire, cand;
    logic                       sys_seen, sys_retire, run;

    function automatic logic [DATA_W-1:0] align_load(
        input logic [DATA_W-1:0] raw,
        input logic [2:0]        off,
        input logic [1:0]        size,
        input logic              uns
    );
        logic [2:0]        offm;
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] keep;
        logic              sb;
        offm = off & 3'(OFF_MASK);
        sh   = raw >> {offm, 3'b000};
        case (size)
            2'd0:    begin keep = DATA_W'(8'hFF);         sb = sh[7];        end
            2'd1:    begin keep = DATA_W'(16'hFFFF);      sb = sh[15];       end
            2'd2:    begin keep = DATA_W'(32'hFFFF_FFFF); sb = sh[31];       end
            default: begin keep = '1;                     sb = sh[DATA_W-1]; end
        endcase
        return (sh & keep) | ({DATA_W{sb & ~uns}} & ~keep);
    endfunction

    assign run = (state_q == ST_RUN);

    always_comb begin
        killed     = '0;
        retire     = '0;
        cand       = '0;
        wb_en_d    = '0;
        wb_data_d  = '0;
        sys_seen   = 1'b0;
        count_d    = count_q;
        // Everything younger than the oldest valid SYSCALL in the bundle is squashed.
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            killed[i] = sys_seen;
            if (in_valid[i] && in_is_syscall[i]) sys_seen = 1'b1;
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            retire[i] = in_valid[i] & ~killed[i] & run;
            cand[i]   = retire[i] & in_reg_write[i] & ~in_is_syscall[i]
                      & (in_reg_dst[i*REG_AW +: REG_AW] != '0);
            count_d   = count_d + CNT_W'(retire[i]);
            wb_data_d[i*DATA_W +: DATA_W] = in_is_load[i]
                ? align_load(in_result[i*DATA_W +: DATA_W], in_byte_off[i*3 +: 3],
                             in_load_size[i*2 +: 2], in_load_unsigned[i])
                : in_result[i*DATA_W +: DATA_W];
        end
        wb_en_d = cand;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            for (int unsigned j = i + 1; j < NUM_CH; j++) begin
                if (cand[j] && in_reg_dst[i*REG_AW +: REG_AW] == in_reg_dst[j*REG_AW +: REG_AW])
                    wb_en_d[i] = 1'b0;
            end
        end
        sys_retire = sys_seen & run;
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            ST_RUN: begin
                if (sys_retire) begin
                    if (DRAIN_CYC == 0) begin
                        state_d = ST_HALT;
                    end else begin
                        state_d = ST_DRAIN;
                        drain_d = DCW'(DRAIN_CYC);
                    end
                end
            end
            ST_DRAIN: begin
                // Leave on the edge where the count would hit zero so halted rises DRAIN_CYC edges after SYSCALL.
                if (drain_q <= DCW'(1)) begin
                    state_d = ST_HALT;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q - DCW'(1);
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            drain_q   <= '0;
            count_q   <= '0;
            wb_en_q   <= '0;
            wb_dst_q  <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            count_q   <= count_d;
            wb_en_q   <= wb_en_d;
            wb_dst_q  <= in_reg_dst;
            wb_data_q <= wb_data_d;
        end
    end

    assign wb_en         = wb_en_q;
    assign wb_dst        = wb_dst_q;
    assign wb_data       = wb_data_q;
    assign retired_count = count_q;
    assign halt_pending  = (state_q == ST_DRAIN);
    assign halted        = (state_q == ST_HALT);

endmodule
